// File: rtl/imul_pkg.sv
// Shared definitions for the iterative shift-add multiplier:
// FSM state encoding and default widths.
package imul_pkg;

  localparam int IMUL_NBITS_DEF     = 32;
  localparam int IMUL_CNT_NBITS_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/imul_iterative_dpath.sv
// Datapath of the iterative multiplier: operand/result registers, the
// iteration counter, the accumulate adder, the shifters and, when
// IMUL_EARLY_EXIT_EN is defined, a zero comparator on the multiplier.
// Only public status (cnt_done, b_zero) leaves this block towards control.
module imul_iterative_dpath
  import imul_pkg::*;
#(
  parameter int p_nbits     = IMUL_NBITS_DEF,
  parameter int p_cnt_nbits = IMUL_CNT_NBITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               calc,
  input  logic [p_nbits-1:0] in_a,
  input  logic [p_nbits-1:0] in_b,
  output logic [p_nbits-1:0] result,
  output logic               cnt_done,
  output logic               b_zero
);

  localparam logic [p_cnt_nbits-1:0] CNT_LAST = p_cnt_nbits'(p_nbits - 1);

  logic [p_nbits-1:0]     a_reg;
  logic [p_nbits-1:0]     b_reg;
  logic [p_nbits-1:0]     result_reg;
  logic [p_cnt_nbits-1:0] cnt;

  logic [p_nbits-1:0]     sum;
  logic [p_nbits-1:0]     a_shl;
  logic [p_nbits-1:0]     b_shr;
  logic [p_cnt_nbits-1:0] cnt_inc;

  // Adder wraps modulo 2^p_nbits; only the low word of the product is kept.
  assign sum     = result_reg + a_reg;
  assign a_shl   = a_reg << 1;
  assign b_shr   = b_reg >> 1;
  assign cnt_inc = cnt + 1'b1;

  assign result   = result_reg;
  assign cnt_done = (cnt == CNT_LAST);

`ifdef IMUL_EARLY_EXIT_EN
  assign b_zero = (b_reg == '0);
`else
  assign b_zero = 1'b0;
`endif

  // Load operands on accept, then one shift-add step per CALC cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      cnt        <= '0;
    end else if (load) begin
      a_reg      <= in_a;
      b_reg      <= in_b;
      result_reg <= '0;
      cnt        <= '0;
    end else if (calc) begin
      if (b_reg[0]) begin
        result_reg <= sum;
      end
      a_reg <= a_shl;
      b_reg <= b_shr;
      cnt   <= cnt_inc;
    end
  end

endmodule

// File: rtl/imul_iterative.sv
// Iterative shift-add multiplier returning the low p_nbits bits of
// in_a*in_b with val/rdy handshakes on both sides. Control timing depends
// only on public signals; define IMUL_EARLY_EXIT_EN to let public-domain
// requests finish as soon as the multiplier is exhausted.
module imul_iterative
  import imul_pkg::*;
#(
  parameter int p_nbits     = IMUL_NBITS_DEF,
  parameter int p_cnt_nbits = IMUL_CNT_NBITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               domain,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_a,
  input  logic [p_nbits-1:0] in_b,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_result
);

  state_t             state;
  state_t             state_next;
  logic               load;
  logic               calc;
  logic               cnt_done;
  logic               b_zero;
  logic               early_exit;
  logic [p_nbits-1:0] result;

  imul_iterative_dpath #(
    .p_nbits     (p_nbits),
    .p_cnt_nbits (p_cnt_nbits)
  ) u_dpath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .calc     (calc),
    .in_a     (in_a),
    .in_b     (in_b),
    .result   (result),
    .cnt_done (cnt_done),
    .b_zero   (b_zero)
  );

  // Secret requests never shortcut; b_zero is constant 0 without the option.
  assign early_exit = ~domain & b_zero;

  // Result is only visible while presented, so aborted work never shows.
  assign out_result = out_val ? result : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state;
    in_rdy     = 1'b0;
    out_val    = 1'b0;
    load       = 1'b0;
    calc       = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        calc = 1'b1;
        if (cnt_done || early_exit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_val = 1'b1;
        if (out_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imul_iterative.sv
// Self-checking bench for imul_iterative: a per-cycle monitor compares the
// DUT against a transaction-level model (product mod 2^32, expected output
// cycle from the iteration rules), and directed tests pin literal values.
module tb_imul_iterative;

  logic        clk;
  logic        reset;
  logic        domain;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_result;

  int n_checks = 0;
  int n_fail   = 0;

  imul_iterative #(.p_nbits(32), .p_cnt_nbits(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .domain     (domain),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_result (out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Cycles from the accept cycle to the first cycle with out_val high:
  // one IDLE (accept) cycle plus the number of CALC cycles taken.
  function automatic int lat_of(input logic [31:0] b, input logic dom);
    int calc_n;
    calc_n = 32;
    if (dom) return 1 + calc_n;
`ifdef IMUL_EARLY_EXIT_EN
    calc_n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) calc_n = i + 2;
    if (calc_n > 32) calc_n = 32;
`else
    if (b == 32'd0) calc_n = 32;
`endif
    return 1 + calc_n;
  endfunction

  typedef struct {
    logic [31:0] prod;
    int          done;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_acc = 0;
  int          n_hs = 0;
  int          last_acc_cyc = 0;
  int          last_val_cyc = 0;
  int          last_hs_cyc = 0;
  logic [31:0] last_res = '0;
  bit          seen_val = 1'b0;

  // Per-cycle comparison against the transaction model.
  always @(negedge clk) begin
    bit   exp_val;
    exp_t e;
    cyc++;
    if (!reset) begin
      chk(in_rdy == 1'b1, "reset_in_rdy", 32'(in_rdy), 32'd1);
      chk(out_val == 1'b0, "reset_out_val", 32'(out_val), 32'd0);
      chk(out_result == 32'd0, "reset_out_result", out_result, 32'd0);
      q.delete();
      seen_val = 1'b0;
    end else begin
      exp_val = (q.size() > 0) && (cyc >= q[0].done);
      chk(out_val == exp_val, "out_val", 32'(out_val), 32'(exp_val));
      chk(in_rdy == (q.size() == 0), "in_rdy", 32'(in_rdy), 32'(q.size() == 0));
      if (exp_val && out_val)
        chk(out_result == q[0].prod, "out_result", out_result, q[0].prod);
      if (out_val && !seen_val) begin
        last_val_cyc = cyc;
        seen_val = 1'b1;
      end
      if (out_val && out_rdy) begin
        last_res    = out_result;
        last_hs_cyc = cyc;
        n_hs++;
        seen_val = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (in_val && in_rdy) begin
        e.prod = in_a * in_b;
        e.done = cyc + lat_of(in_b, domain);
        q.push_back(e);
        last_acc_cyc = cyc;
        n_acc++;
      end
    end
  end

  bit rdy_rand = 1'b0;
  bit rdy_val  = 1'b1;

  // Consumer ready: either random back-pressure or a directed level.
  always @(posedge clk) begin
    #2;
    if (rdy_rand) out_rdy = 1'($urandom_range(0, 1));
    else          out_rdy = rdy_val;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input string nm);
    int t = 0;
    while (n_acc < target && t < 200) begin
      step();
      t++;
    end
    chk(n_acc >= target, nm, 32'(n_acc), 32'(target));
  endtask

  task automatic wait_hs(input int target, input string nm);
    int t = 0;
    while (n_hs < target && t < 300) begin
      step();
      t++;
    end
    chk(n_hs >= target, nm, 32'(n_hs), 32'(target));
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic dom);
    int acc_t;
    int hs_t;
    acc_t  = n_acc + 1;
    hs_t   = n_hs + 1;
    domain = dom;
    in_a   = a;
    in_b   = b;
    in_val = 1'b1;
    wait_acc(acc_t, "accept_timeout");
    in_val = 1'b0;
    in_a   = $urandom;
    in_b   = $urandom;
    wait_hs(hs_t, "result_timeout");
  endtask

  initial begin
    int          t;
    int          hs_before;
    logic [31:0] r1;
    int          h1;
    logic [31:0] ra;
    logic [31:0] rb;

    reset  = 1'b0;
    domain = 1'b0;
    in_val = 1'b0;
    in_a   = '0;
    in_b   = '0;
    out_rdy = 1'b1;
    repeat (3) step();
    chk(in_rdy == 1'b1, "por_in_rdy", 32'(in_rdy), 32'd1);
    chk(out_val == 1'b0, "por_out_val", 32'(out_val), 32'd0);
    reset = 1'b1;
    repeat (2) step();

    // Basic product and latency.
    do_op(32'd6, 32'd7, 1'b0);
    chk(last_res == 32'd42, "mul_6x7", last_res, 32'd42);
`ifdef IMUL_EARLY_EXIT_EN
    chk(last_val_cyc - last_acc_cyc == 5, "lat_6x7", 32'(last_val_cyc - last_acc_cyc), 32'd5);
`else
    chk(last_val_cyc - last_acc_cyc == 33, "lat_6x7", 32'(last_val_cyc - last_acc_cyc), 32'd33);
`endif

    // Wrap-around / two's-complement low word.
    do_op(32'hFFFF_FFFF, 32'h0000_0003, 1'b1);
    chk(last_res == 32'hFFFF_FFFD, "mul_m1x3", last_res, 32'hFFFF_FFFD);
    chk(last_val_cyc - last_acc_cyc == 33, "lat_secret", 32'(last_val_cyc - last_acc_cyc), 32'd33);

    // Abort mid-calculation with reset.
    hs_before = n_hs;
    domain = 1'b0;
    in_a   = 32'd7;
    in_b   = 32'd9;
    in_val = 1'b1;
    wait_acc(n_acc + 1, "abort_accept");
    in_val = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    step();
    chk(in_rdy == 1'b1, "abort_in_rdy", 32'(in_rdy), 32'd1);
    chk(out_val == 1'b0, "abort_out_val", 32'(out_val), 32'd0);
    chk(out_result == 32'd0, "abort_out_result", out_result, 32'd0);
    reset = 1'b1;
    repeat (40) step();
    chk(n_hs == hs_before, "abort_no_result", 32'(n_hs), 32'(hs_before));

    // Consumer stall in DONE; busy requests are ignored.
    rdy_val = 1'b0;
    step();
    domain = 1'b0;
    in_a   = 32'd5;
    in_b   = 32'd5;
    in_val = 1'b1;
    wait_acc(n_acc + 1, "stall_accept");
    in_val = 1'b0;
    t = 0;
    while (!out_val && t < 100) begin
      step();
      t++;
    end
    chk(out_val == 1'b1, "stall_out_val", 32'(out_val), 32'd1);
    in_a   = 32'd9;
    in_b   = 32'd9;
    in_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk(out_result == 32'd25, "stall_result", out_result, 32'd25);
      chk(in_rdy == 1'b0, "stall_in_rdy", 32'(in_rdy), 32'd0);
    end
    hs_before = n_hs;
    rdy_val = 1'b1;
    wait_acc(n_acc + 1, "stall_next_accept");
    in_val = 1'b0;
    chk(last_res == 32'd25, "stall_taken", last_res, 32'd25);
    chk(last_acc_cyc == last_hs_cyc + 1, "stall_next_cycle", 32'(last_acc_cyc), 32'(last_hs_cyc + 1));
    wait_hs(hs_before + 2, "stall_next_result");
    chk(last_res == 32'd81, "mul_9x9", last_res, 32'd81);

    // Back-to-back: 3x4 then 0x123 with the second request already waiting.
    hs_before = n_hs;
    domain = 1'b0;
    in_a   = 32'd3;
    in_b   = 32'd4;
    in_val = 1'b1;
    wait_acc(n_acc + 1, "b2b_accept1");
    in_a = 32'd0;
    in_b = 32'd123;
    wait_hs(hs_before + 1, "b2b_result1");
    r1 = last_res;
    h1 = last_hs_cyc;
    wait_acc(n_acc + 1, "b2b_accept2");
    in_val = 1'b0;
    chk(r1 == 32'd12, "b2b_first", r1, 32'd12);
    chk(last_acc_cyc == h1 + 1, "b2b_gap", 32'(last_acc_cyc), 32'(h1 + 1));
    wait_hs(hs_before + 2, "b2b_result2");
    chk(last_res == 32'd0, "b2b_second", last_res, 32'd0);

`ifdef IMUL_EARLY_EXIT_EN
    do_op(32'd7, 32'd1, 1'b0);
    chk(last_res == 32'd7, "early_pub_res", last_res, 32'd7);
    chk(last_val_cyc - last_acc_cyc == 3, "early_pub_lat", 32'(last_val_cyc - last_acc_cyc), 32'd3);
    do_op(32'd7, 32'd1, 1'b1);
    chk(last_res == 32'd7, "early_sec_res", last_res, 32'd7);
    chk(last_val_cyc - last_acc_cyc == 33, "early_sec_lat", 32'(last_val_cyc - last_acc_cyc), 32'd33);
`endif

    // Randomized operands, domains and consumer back-pressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(0, 15));
        2: ra = 32'hFFFF_FFFF;
        3: rb = 32'h8000_0000;
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)));
      chk(last_res == ra * rb, "rand_product", last_res, ra * rb);
    end
    rdy_rand = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
